// File: rtl/weekday_counter_display.sv
// weekday_counter_display
// Holds the current weekday (0=Mon..6=Sun) and advances it on day_tick in RUN
// mode. In SET mode the day is adjusted with inc/dec pulses and the display blinks.
// Any mode may load a day directly. The day is shown as a two-letter
// abbreviation on a 2-digit multiplexed 7-segment display.
module weekday_counter_display #(
   parameter int SCAN_DIV       = 1000,
   parameter int BLINK_DIV      = 25000000,
   parameter int START_DAY      = 0,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       day_tick,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic       dec_btn,
   input  logic       load_en,
   input  logic [2:0] load_day,
   output logic [2:0] day_o,
   output logic       set_mode,
   output logic       week_wrap,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   localparam logic ST_RUN = 1'b0;
   localparam logic ST_SET = 1'b1;

   // Active-high glyph codes, {A,B,C,D,E,F,G}
   localparam logic [6:0] G_M = 7'h76;
   localparam logic [6:0] G_O = 7'h7E;
   localparam logic [6:0] G_T = 7'h0F;
   localparam logic [6:0] G_U = 7'h3E;
   localparam logic [6:0] G_W = 7'h3F;
   localparam logic [6:0] G_E = 7'h4F;
   localparam logic [6:0] G_H = 7'h37;
   localparam logic [6:0] G_F = 7'h47;
   localparam logic [6:0] G_R = 7'h05;
   localparam logic [6:0] G_S = 7'h5B;
   localparam logic [6:0] G_A = 7'h77;
   localparam logic [6:0] G_BLANK = 7'h00;

   // Internal "left digit enabled" pattern; slot 0 = left, slot 1 = right
   localparam logic [1:0] AN_LEFT  = 2'b10;
   localparam logic [1:0] AN_RIGHT = 2'b01;

   logic [2:0]         day_q, day_d;
   logic               state_q, state_d;
   logic               wrap_q, wrap_d;
   logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
   logic               slot_q, slot_d;
   logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
   logic               phase_q, phase_d;
   logic [6:0]         seg_q, seg_d;
   logic [1:0]         an_q, an_d;

   // Letter for one digit of a day's abbreviation; unused codes show blank
   function automatic logic [6:0] glyph(input logic [2:0] d, input logic right);
      logic [6:0] g;
      case (d)
         3'd0:    g = right ? G_O : G_M;
         3'd1:    g = right ? G_U : G_T;
         3'd2:    g = right ? G_E : G_W;
         3'd3:    g = right ? G_H : G_T;
         3'd4:    g = right ? G_R : G_F;
         3'd5:    g = right ? G_A : G_S;
         3'd6:    g = right ? G_U : G_S;
         default: g = G_BLANK;
      endcase
      return g;
   endfunction

   // Day / mode next state: load beats mode toggle, which beats inc/dec and tick
   always_comb begin
      day_d   = day_q;
      state_d = state_q;
      wrap_d  = 1'b0;
      if (load_en) begin
         if (load_day <= 3'd6) begin
            day_d = load_day;
         end else begin
            day_d = day_q;
         end
      end else if (mode_btn) begin
         state_d = (state_q == ST_RUN) ? ST_SET : ST_RUN;
      end else if (state_q == ST_SET) begin
         if (inc_btn && !dec_btn) begin
            day_d = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
         end else if (dec_btn && !inc_btn) begin
            day_d = (day_q == 3'd0) ? 3'd6 : day_q - 3'd1;
         end else begin
            day_d = day_q;
         end
      end else if (day_tick) begin
         day_d  = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
         wrap_d = (day_q == 3'd6);
      end else begin
         day_d = day_q;
      end
   end

   // Digit scan: slot flips every SCAN_DIV cycles
   always_comb begin
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         slot_d     = ~slot_q;
      end else begin
         scan_cnt_d = scan_cnt_q + SCAN_W'(1);
         slot_d     = slot_q;
      end
   end

   // Blink phase: held at visible outside SET and restarted on every SET entry
   always_comb begin
      if ((state_d != ST_SET) || (state_q != ST_SET)) begin
         blink_cnt_d = '0;
         phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d = '0;
         phase_d     = ~phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + BLINK_W'(1);
         phase_d     = phase_q;
      end
   end

   // Display drive built from the previous cycle's day, slot and blink phase
   always_comb begin
      if (phase_q) begin
         seg_d = G_BLANK;
      end else begin
         seg_d = glyph(day_q, slot_q);
      end
      an_d = slot_q ? AN_RIGHT : AN_LEFT;
   end

   // State registers; reset shows a blank display with the left digit enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         day_q       <= 3'(START_DAY);
         state_q     <= ST_RUN;
         wrap_q      <= 1'b0;
         scan_cnt_q  <= '0;
         slot_q      <= 1'b0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         seg_q       <= G_BLANK;
         an_q        <= AN_LEFT;
      end else begin
         day_q       <= day_d;
         state_q     <= state_d;
         wrap_q      <= wrap_d;
         scan_cnt_q  <= scan_cnt_d;
         slot_q      <= slot_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign day_o     = day_q;
   assign set_mode  = (state_q == ST_SET);
   assign week_wrap = wrap_q;
   assign seg       = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign an        = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_weekday_counter_display.sv
// Directed testbench for weekday_counter_display (SCAN_DIV=4, BLINK_DIV=8,
// START_DAY=0, segments active-high, anodes active-low at the pins).
module tb_weekday_counter_display;

   logic       clk;
   logic       rst_n;
   logic       day_tick, mode_btn, inc_btn, dec_btn, load_en;
   logic [2:0] load_day;
   logic [2:0] day_o;
   logic       set_mode, week_wrap;
   logic [6:0] seg;
   logic [1:0] an;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int cyc       = 0;   // rising edges since reset release

   weekday_counter_display #(
      .SCAN_DIV(4), .BLINK_DIV(8), .START_DAY(0),
      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .day_tick(day_tick), .mode_btn(mode_btn),
      .inc_btn(inc_btn), .dec_btn(dec_btn), .load_en(load_en),
      .load_day(load_day), .day_o(day_o), .set_mode(set_mode),
      .week_wrap(week_wrap), .seg(seg), .an(an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to predict the scan slot
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Hand-written glyph table (active-high)
   function automatic logic [6:0] exp_glyph(input int d, input int right);
      logic [6:0] l [7];
      logic [6:0] r [7];
      l = '{7'h76, 7'h0F, 7'h3F, 7'h0F, 7'h47, 7'h5B, 7'h5B};
      r = '{7'h7E, 7'h3E, 7'h4F, 7'h37, 7'h05, 7'h77, 7'h3E};
      return (right != 0) ? r[d] : l[d];
   endfunction

   // Display check: slot latched at edge cyc-1 is ((cyc-1)/4)%2, seg/an lag one cycle
   task automatic check_disp(input string tag, input int d, input int blank);
      int sl;
      sl = ((cyc - 1) / 4) % 2;
      check({tag, "_an"}, {30'd0, an}, (sl != 0) ? 32'h2 : 32'h1);
      check({tag, "_seg"}, {25'd0, seg}, (blank != 0) ? 32'h0 : {25'd0, exp_glyph(d, sl)});
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   int wraps;

   initial begin
      rst_n = 1'b0; day_tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
      dec_btn = 1'b0; load_en = 1'b0; load_day = 3'd0;

      // 1: reset values and scan pattern
      #12;
      check("rst_day", {29'd0, day_o}, 32'd0);
      check("rst_set", {31'd0, set_mode}, 32'd0);
      check("rst_wrap", {31'd0, week_wrap}, 32'd0);
      check("rst_seg", {25'd0, seg}, 32'h00);
      check("rst_an", {30'd0, an}, 32'h1);
      @(negedge clk); rst_n = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         step();
         check_disp("scan", 0, 0);
      end

      // 2: RUN wrap 6->0 and a full week
      load_en = 1'b1; load_day = 3'd6; step(); load_en = 1'b0;
      check("load6", {29'd0, day_o}, 32'd6);
      step(); check_disp("disp6", 6, 0);
      day_tick = 1'b1; step(); day_tick = 1'b0;
      check("wrap_day", {29'd0, day_o}, 32'd0);
      check("wrap_pulse", {31'd0, week_wrap}, 32'd1);
      step();
      check("wrap_end", {31'd0, week_wrap}, 32'd0);
      check_disp("disp0", 0, 0);
      wraps = 0;
      for (int k = 0; k < 7; k++) begin
         day_tick = 1'b1; step(); day_tick = 1'b0;
         if (week_wrap) wraps++;
         step();
         if (week_wrap) wraps++;
      end
      check("week_day", {29'd0, day_o}, 32'd0);
      check("week_wraps", wraps, 32'd1);

      // 3: SET adjust
      mode_btn = 1'b1; step(); mode_btn = 1'b0;
      check("set_on", {31'd0, set_mode}, 32'd1);
      dec_btn = 1'b1; step(); dec_btn = 1'b0;
      check("dec_wrap", {29'd0, day_o}, 32'd6);
      inc_btn = 1'b1; step(); inc_btn = 1'b0;
      check("inc_wrap", {29'd0, day_o}, 32'd0);
      inc_btn = 1'b1; dec_btn = 1'b1; step(); inc_btn = 1'b0; dec_btn = 1'b0;
      check("incdec", {29'd0, day_o}, 32'd0);
      day_tick = 1'b1; step(); day_tick = 1'b0;
      check("tick_set", {29'd0, day_o}, 32'd0);
      check("tick_set_wrap", {31'd0, week_wrap}, 32'd0);
      inc_btn = 1'b1; step(); inc_btn = 1'b0;
      check("inc1", {29'd0, day_o}, 32'd1);
      dec_btn = 1'b1; step(); dec_btn = 1'b0;
      check("dec1", {29'd0, day_o}, 32'd0);

      // 4: blink timing from a fresh SET entry
      mode_btn = 1'b1; step(); mode_btn = 1'b0;
      check("run_again", {31'd0, set_mode}, 32'd0);
      step(); step();
      mode_btn = 1'b1; step(); mode_btn = 1'b0;
      check("set_again", {31'd0, set_mode}, 32'd1);
      for (int j = 1; j <= 24; j++) begin
         step();
         check_disp("blink", 0, (j >= 9 && j <= 16) ? 1 : 0);
      end
      mode_btn = 1'b1; step(); mode_btn = 1'b0;
      check("run_exit", {31'd0, set_mode}, 32'd0);
      for (int j = 0; j < 20; j++) begin
         step();
         check_disp("run_noblink", 0, 0);
      end

      // 5: load priority and invalid load
      load_en = 1'b1; load_day = 3'd3; mode_btn = 1'b1; step();
      load_en = 1'b0; mode_btn = 1'b0;
      check("ldpri_day", {29'd0, day_o}, 32'd3);
      check("ldpri_mode", {31'd0, set_mode}, 32'd0);
      load_en = 1'b1; load_day = 3'd7; step(); load_en = 1'b0;
      check("ld7", {29'd0, day_o}, 32'd3);
      step(); check_disp("disp3", 3, 0);

      // 6: asynchronous reset in the middle of SET
      mode_btn = 1'b1; step(); mode_btn = 1'b0;
      check("pre_rst_set", {31'd0, set_mode}, 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_day", {29'd0, day_o}, 32'd0);
      check("arst_set", {31'd0, set_mode}, 32'd0);
      check("arst_seg", {25'd0, seg}, 32'h00);
      check("arst_an", {30'd0, an}, 32'h1);
      @(negedge clk); rst_n = 1'b1;
      step(); check_disp("post_rst", 0, 0);
      day_tick = 1'b1; step(); day_tick = 1'b0;
      check("post_rst_tick", {29'd0, day_o}, 32'd1);
      check("post_rst_run", {31'd0, set_mode}, 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
